// File: rtl/mem_wb_stage_if.sv
// Data-memory request/acknowledge bus between mem_wb_stage (master) and the data memory (slave).
interface mem_wb_stage_if;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_ack;

  modport master (
    output mem_req, mem_we, mem_addr, mem_wdata,
    input  mem_rdata, mem_ack
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_wdata,
    output mem_rdata, mem_ack
  );
endinterface

// File: rtl/mem_wb_stage.sv
// MEM stage: data-memory req/ack access, MEM/WB pipeline register and MEM_stall back to EX/MEM.
// Optional macro MEM_TIMEOUT_EN forces completion after MEM_TIMEOUT BUSY cycles and sets a sticky mem_error.
module mem_wb_stage #(
  parameter int MEM_TIMEOUT = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [31:0]           ALU_out,
  input  logic [4:0]            rd_out,
  input  logic [4:0]            rt_out,
  input  logic [31:0]           dato_B_out,
  input  logic                  Mux_flag_2_MEM,
  input  logic                  Mux_flag_3_MEM,
  input  logic                  mem_flag_rd_MEM,
  input  logic                  mem_flag_wr_MEM,
  input  logic                  banco_flag_wr_MEM,
  mem_wb_stage_if.master        mem,
  output logic                  MEM_stall,
  output logic [31:0]           wb_data,
  output logic [4:0]            wb_reg,
  output logic                  wb_we,
  output logic                  mem_error
);

  if (MEM_TIMEOUT < 2 || MEM_TIMEOUT > 255) begin : g_param_check
    $error("mem_wb_stage: MEM_TIMEOUT must be in 2..255");
  end

  typedef enum logic {ST_IDLE, ST_BUSY} state_t;

  state_t      state_q, state_d;
  logic        req_q, req_d;
  logic        we_q, we_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] wb_data_q, wb_data_d;
  logic [4:0]  wb_reg_q, wb_reg_d;
  logic        wb_we_q, wb_we_d;
  logic        err_q, err_d;

  logic        mem_op;
  logic        timeout;
  logic        complete;
  logic [4:0]  dest_reg;

  assign mem_op   = mem_flag_rd_MEM | mem_flag_wr_MEM;
  assign dest_reg = Mux_flag_2_MEM ? rd_out : rt_out;

`ifdef MEM_TIMEOUT_EN
  logic [7:0] cnt_q, cnt_d;

  // A simultaneous ack takes priority, so a timeout only exists when ack is low.
  assign timeout = (state_q == ST_BUSY) && !mem.mem_ack && (cnt_q == 8'(MEM_TIMEOUT - 1));

  always_comb begin
    cnt_d = cnt_q;
    if (state_q == ST_IDLE && mem_op) begin
      cnt_d = 8'd0;
    end else if (state_q == ST_BUSY) begin
      cnt_d = cnt_q + 8'd1;
    end
  end

  always_ff @(negedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= 8'd0;
    end else begin
      cnt_q <= cnt_d;
    end
  end
`else
  assign timeout = 1'b0;
`endif

  assign complete  = (state_q == ST_BUSY) && (mem.mem_ack || timeout);
  // EX/MEM advances on the same edge that captures the completion.
  assign MEM_stall = rst_n & mem_op & ~complete;

  always_comb begin
    state_d   = state_q;
    req_d     = req_q;
    we_d      = we_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    wb_data_d = wb_data_q;
    wb_reg_d  = wb_reg_q;
    wb_we_d   = wb_we_q;
    err_d     = err_q;
    case (state_q)
      ST_IDLE: begin
        if (mem_op) begin
          req_d   = 1'b1;
          we_d    = mem_flag_wr_MEM;
          addr_d  = ALU_out;
          wdata_d = dato_B_out;
          wb_we_d = 1'b0;
          state_d = ST_BUSY;
        end else begin
          wb_data_d = ALU_out;
          wb_reg_d  = dest_reg;
          wb_we_d   = banco_flag_wr_MEM;
        end
      end
      ST_BUSY: begin
        if (complete) begin
          req_d     = 1'b0;
          state_d   = ST_IDLE;
          wb_data_d = Mux_flag_3_MEM ? (timeout ? 32'd0 : mem.mem_rdata) : ALU_out;
          wb_reg_d  = dest_reg;
          wb_we_d   = banco_flag_wr_MEM;
          err_d     = err_q | timeout;
        end else begin
          wb_we_d = 1'b0;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(negedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      req_q     <= 1'b0;
      we_q      <= 1'b0;
      addr_q    <= 32'd0;
      wdata_q   <= 32'd0;
      wb_data_q <= 32'd0;
      wb_reg_q  <= 5'd0;
      wb_we_q   <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      req_q     <= req_d;
      we_q      <= we_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      wb_data_q <= wb_data_d;
      wb_reg_q  <= wb_reg_d;
      wb_we_q   <= wb_we_d;
      err_q     <= err_d;
    end
  end

  assign mem.mem_req   = req_q;
  assign mem.mem_we    = we_q;
  assign mem.mem_addr  = addr_q;
  assign mem.mem_wdata = wdata_q;
  assign wb_data       = wb_data_q;
  assign wb_reg        = wb_reg_q;
  assign wb_we         = wb_we_q;
  assign mem_error     = err_q;

endmodule

// File: tb/tb_mem_wb_stage.sv
// Self-checking bench for mem_wb_stage: directed and random instruction sequences against a transaction-level model.
module tb_mem_wb_stage;
  localparam int TMO = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] ALU_out = '0;
  logic [4:0]  rd_out = '0;
  logic [4:0]  rt_out = '0;
  logic [31:0] dato_B_out = '0;
  logic        Mux_flag_2_MEM = 1'b0;
  logic        Mux_flag_3_MEM = 1'b0;
  logic        mem_flag_rd_MEM = 1'b0;
  logic        mem_flag_wr_MEM = 1'b0;
  logic        banco_flag_wr_MEM = 1'b0;
  logic        MEM_stall;
  logic [31:0] wb_data;
  logic [4:0]  wb_reg;
  logic        wb_we;
  logic        mem_error;

  mem_wb_stage_if bus ();

  mem_wb_stage #(.MEM_TIMEOUT(TMO)) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .ALU_out          (ALU_out),
    .rd_out           (rd_out),
    .rt_out           (rt_out),
    .dato_B_out       (dato_B_out),
    .Mux_flag_2_MEM   (Mux_flag_2_MEM),
    .Mux_flag_3_MEM   (Mux_flag_3_MEM),
    .mem_flag_rd_MEM  (mem_flag_rd_MEM),
    .mem_flag_wr_MEM  (mem_flag_wr_MEM),
    .banco_flag_wr_MEM(banco_flag_wr_MEM),
    .mem              (bus.master),
    .MEM_stall        (MEM_stall),
    .wb_data          (wb_data),
    .wb_reg           (wb_reg),
    .wb_we            (wb_we),
    .mem_error        (mem_error)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Model of the architecturally visible MEM/WB state
  logic [31:0] exp_wb_data = '0;
  logic [4:0]  exp_wb_reg  = '0;
  logic        exp_wb_we   = 1'b0;
  logic        exp_err     = 1'b0;

  // Drive and sample at posedge+1; the DUT updates on negedge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One instruction through the stage; ack_delay = BUSY cycle (1-based) in which mem_ack is raised.
  task automatic run_op(input string tag, input logic [31:0] alu, input logic [31:0] b,
                        input logic [4:0] rd, input logic [4:0] rt, input logic m2, input logic m3,
                        input logic rdf, input logic wrf, input logic banco,
                        input int ack_delay, input logic [31:0] rdata);
    logic        is_mem;
    logic        tmo;
    int          done_at;
    logic [31:0] load_val;
    is_mem = rdf | wrf;
    ALU_out = alu; dato_B_out = b; rd_out = rd; rt_out = rt;
    Mux_flag_2_MEM = m2; Mux_flag_3_MEM = m3;
    mem_flag_rd_MEM = rdf; mem_flag_wr_MEM = wrf; banco_flag_wr_MEM = banco;
    bus.mem_ack = 1'($urandom_range(0, 1));
    bus.mem_rdata = $urandom;
    #1;
    checks++;
    if (MEM_stall !== is_mem) begin
      errors++;
      $display("FAIL %s stall_at_issue: got %b want %b", tag, MEM_stall, is_mem);
    end
    if (!is_mem) begin
      step();
      exp_wb_data = alu; exp_wb_reg = m2 ? rd : rt; exp_wb_we = banco;
      checks++;
      if ({wb_data, wb_reg, wb_we, mem_error, bus.mem_req} !== {exp_wb_data, exp_wb_reg, exp_wb_we, exp_err, 1'b0}) begin
        errors++;
        $display("FAIL %s alu_retire: got data=%h reg=%0d we=%b err=%b req=%b want data=%h reg=%0d we=%b err=%b req=0",
                 tag, wb_data, wb_reg, wb_we, mem_error, bus.mem_req, exp_wb_data, exp_wb_reg, exp_wb_we, exp_err);
      end else
        $display("%s: ALU op retired data=%h reg=%0d we=%b", tag, wb_data, wb_reg, wb_we);
      mem_flag_rd_MEM = 1'b0; mem_flag_wr_MEM = 1'b0; bus.mem_ack = 1'b0;
      return;
    end
`ifdef MEM_TIMEOUT_EN
    tmo = (ack_delay > TMO);
    done_at = tmo ? TMO : ack_delay;
`else
    tmo = 1'b0;
    done_at = ack_delay;
`endif
    step();
    checks++;
    if ({bus.mem_req, bus.mem_we, bus.mem_addr, bus.mem_wdata, wb_we, wb_data, wb_reg} !==
        {1'b1, wrf, alu, b, 1'b0, exp_wb_data, exp_wb_reg}) begin
      errors++;
      $display("FAIL %s mem_issue: got req=%b we=%b addr=%h wdata=%h wb_we=%b wb_data=%h wb_reg=%0d want req=1 we=%b addr=%h wdata=%h wb_we=0 wb_data=%h wb_reg=%0d",
               tag, bus.mem_req, bus.mem_we, bus.mem_addr, bus.mem_wdata, wb_we, wb_data, wb_reg,
               wrf, alu, b, exp_wb_data, exp_wb_reg);
    end
    for (int k = 1; k <= done_at; k++) begin
      bus.mem_ack = (k == ack_delay);
      if (k == ack_delay) bus.mem_rdata = rdata;
      #1;
      checks++;
      if (MEM_stall !== (k != done_at)) begin
        errors++;
        $display("FAIL %s stall_busy_cycle%0d: got %b want %b", tag, k, MEM_stall, (k != done_at));
      end
      step();
      bus.mem_ack = 1'b0;
      if (k < done_at) begin
        checks++;
        if ({bus.mem_req, wb_we} !== 2'b10) begin
          errors++;
          $display("FAIL %s busy_hold%0d: got req=%b wb_we=%b want req=1 wb_we=0", tag, k, bus.mem_req, wb_we);
        end
      end
    end
    load_val = tmo ? 32'd0 : rdata;
    exp_wb_data = m3 ? load_val : alu;
    exp_wb_reg = m2 ? rd : rt;
    exp_wb_we = banco;
    exp_err = exp_err | tmo;
    checks++;
    if ({wb_data, wb_reg, wb_we, mem_error, bus.mem_req} !== {exp_wb_data, exp_wb_reg, exp_wb_we, exp_err, 1'b0}) begin
      errors++;
      $display("FAIL %s mem_retire: got data=%h reg=%0d we=%b err=%b req=%b want data=%h reg=%0d we=%b err=%b req=0",
               tag, wb_data, wb_reg, wb_we, mem_error, bus.mem_req, exp_wb_data, exp_wb_reg, exp_wb_we, exp_err);
    end else
      $display("%s: mem op (we=%b) retired after %0d busy cycles data=%h reg=%0d we=%b err=%b",
               tag, wrf, done_at, wb_data, wb_reg, wb_we, mem_error);
    mem_flag_rd_MEM = 1'b0; mem_flag_wr_MEM = 1'b0;
  endtask

  task automatic test_reset();
    #1;
    checks++;
    if ({bus.mem_req, bus.mem_we, bus.mem_addr, bus.mem_wdata, MEM_stall, wb_data, wb_reg, wb_we, mem_error} !== '0) begin
      errors++;
      $display("FAIL reset_state: got req=%b we=%b addr=%h wdata=%h stall=%b wb_data=%h wb_reg=%0d wb_we=%b err=%b want all 0",
               bus.mem_req, bus.mem_we, bus.mem_addr, bus.mem_wdata, MEM_stall, wb_data, wb_reg, wb_we, mem_error);
    end else
      $display("reset: all outputs 0");
    step();
    step();
    rst_n = 1'b1;
  endtask

  task automatic test_alu();
    run_op("alu_a5", 32'h0000_00A5, 32'h0, 5'd5, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1, 32'h0);
    run_op("alu_rt", 32'hCAFE_0001, 32'h0, 5'd3, 5'd17, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1, 32'h0);
  endtask

  task automatic test_load();
    run_op("load", 32'h0000_0100, 32'h0, 5'd0, 5'd9, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 3, 32'hDEAD_BEEF);
  endtask

  task automatic test_back_to_back();
    run_op("store", 32'h0000_0020, 32'h0000_1234, 5'd1, 5'd2, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1, 32'h0);
    run_op("alu_after_store", 32'h0000_0777, 32'h0, 5'd7, 5'd8, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1, 32'h0);
    run_op("load_b2b_0", 32'h0000_0040, 32'h0, 5'd4, 5'd6, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1, 32'h1111_2222);
    run_op("load_b2b_1", 32'h0000_0044, 32'h0, 5'd4, 5'd6, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1, 32'h3333_4444);
  endtask

  task automatic test_both_flags();
    run_op("rd_and_wr", 32'h0000_0080, 32'h5555_AAAA, 5'd10, 5'd11, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 2, 32'h0);
  endtask

  task automatic test_reset_mid_access();
    ALU_out = 32'h0000_0200; dato_B_out = 32'h0; rt_out = 5'd12; rd_out = 5'd13;
    Mux_flag_2_MEM = 1'b1; Mux_flag_3_MEM = 1'b1;
    mem_flag_rd_MEM = 1'b1; mem_flag_wr_MEM = 1'b0; banco_flag_wr_MEM = 1'b1; bus.mem_ack = 1'b0;
    step();
    step();
    rst_n = 1'b0;
    #1;
    checks++;
    if ({bus.mem_req, MEM_stall, wb_we, mem_error, wb_data} !== '0) begin
      errors++;
      $display("FAIL reset_mid_busy: got req=%b stall=%b wb_we=%b err=%b wb_data=%h want all 0",
               bus.mem_req, MEM_stall, wb_we, mem_error, wb_data);
    end else
      $display("reset_mid_busy: outputs cleared");
    bus.mem_ack = 1'b1;
    bus.mem_rdata = 32'hBAD0_BAD0;
    step();
    rst_n = 1'b1;
    exp_wb_data = '0; exp_wb_reg = '0; exp_wb_we = 1'b0; exp_err = 1'b0;
    run_op("alu_after_reset", 32'h0000_0321, 32'h0, 5'd21, 5'd22, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1, 32'h0);
  endtask

  // Under MEM_TIMEOUT_EN this times out after TMO cycles; otherwise it waits for the late ack.
  task automatic test_timeout();
    run_op("load_no_ack", 32'h0000_0300, 32'h0, 5'd0, 5'd14, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 12, 32'h7777_8888);
    run_op("alu_after_tmo", 32'h0000_0ABC, 32'h0, 5'd15, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1, 32'h0);
    run_op("load_ack_at_limit", 32'h0000_0304, 32'h0, 5'd16, 5'd0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, TMO, 32'h9999_AAAA);
  endtask

  task automatic test_random();
    for (int i = 0; i < 40; i++) begin
      logic [1:0] kind;
      kind = 2'($urandom_range(0, 3));
      run_op($sformatf("rand%0d", i), $urandom, $urandom, 5'($urandom), 5'($urandom),
             1'($urandom), 1'($urandom), kind[0], kind[1], 1'($urandom),
             int'($urandom_range(1, 6)), $urandom);
    end
  endtask

  initial begin
    test_reset();
    test_alu();
    test_load();
    test_back_to_back();
    test_both_flags();
    test_reset_mid_access();
    test_random();
    test_timeout();
    run_op("final_alu", 32'h0000_0F0F, 32'h0, 5'd30, 5'd31, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1, 32'h0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog expired");
  end
endmodule

// File: doc/mem_wb_stage.md
Name: mem_wb_stage

Overview:
- Consumer side of the EX/MEM pipeline register: takes the latched EX/MEM outputs, performs the data-memory access over a req/ack handshake, and holds the MEM/WB pipeline register that feeds write-back.
- Generates MEM_stall back to the EX/MEM register (used as its EX_MEM_enable, 1 = hold) while a memory access is outstanding.
- Sits between EX_MEM and the register bank write port.

Parameters:
- MEM_TIMEOUT, 16, cycles in BUSY without mem_ack before a forced completion; used only with MEM_TIMEOUT_EN; legal range 2..255.

Ports:
- clk  in  1  pipeline clock; all state updates on negedge clk, matching the EX/MEM register.
- rst_n  in  1  asynchronous active-low reset.
- ALU_out  in  32  EX/MEM ALU result; also the memory address.
- rd_out  in  5  EX/MEM rd field.
- rt_out  in  5  EX/MEM rt field.
- dato_B_out  in  32  store data.
- Mux_flag_2_MEM  in  1  destination select: 1 = rd, 0 = rt.
- Mux_flag_3_MEM  in  1  write-back select: 1 = memory read data, 0 = ALU result.
- mem_flag_rd_MEM  in  1  load.
- mem_flag_wr_MEM  in  1  store.
- banco_flag_wr_MEM  in  1  register-bank write enable.
- mem_req  out  1  memory request, registered.
- mem_we  out  1  1 = write, registered.
- mem_addr  out  32  registered address.
- mem_wdata  out  32  registered store data.
- mem_rdata  in  32  memory read data, valid with mem_ack.
- mem_ack  in  1  access complete.
- MEM_stall  out  1  combinational hold request to EX/MEM.
- wb_data  out  32  MEM/WB write-back data.
- wb_reg  out  5  MEM/WB destination register.
- wb_we  out  1  MEM/WB register-bank write enable.
- mem_error  out  1  sticky timeout flag.

Behaviour:
- Reset (rst_n low, asynchronous):
  - All outputs go to 0 and the FSM goes to IDLE.
  - This applies mid-access as well: mem_req drops immediately and any pending result is discarded.
- Definitions:
  - mem_op = mem_flag_rd_MEM | mem_flag_wr_MEM.
  - If both flags are high, the access is a store (mem_we = 1) and no error is raised.
- FSM states: IDLE and BUSY.
- IDLE, mem_op = 0: at the next negedge, latch the MEM/WB register:
  - wb_data = ALU_out.
  - wb_reg = Mux_flag_2_MEM ? rd_out : rt_out.
  - wb_we = banco_flag_wr_MEM.
  - Latency is 1 cycle.
- IDLE, mem_op = 1: at the next negedge:
  - mem_req = 1, mem_we = mem_flag_wr_MEM, mem_addr = ALU_out, mem_wdata = dato_B_out.
  - MEM/WB is loaded with a bubble (wb_we = 0; wb_data and wb_reg hold).
  - Go to BUSY.
- BUSY, mem_ack = 0: hold all memory outputs and keep MEM/WB at the bubble.
- BUSY, mem_ack = 1 (completion): at the next negedge:
  - mem_req = 0, go to IDLE.
  - MEM/WB gets wb_data = Mux_flag_3_MEM ? mem_rdata : ALU_out, wb_reg as above, wb_we = banco_flag_wr_MEM.
- MEM_stall = mem_op & ~(state == BUSY & complete), where complete = mem_ack (or timeout).
  - EX/MEM therefore advances on the same negedge that completion is captured.
  - Minimum load/store latency is 2 cycles; back-to-back memory ops each take at least 2 cycles.
- mem_ack while IDLE is ignored.
- EX/MEM inputs are stable while MEM_stall is high. Inputs sampled at completion are the same instruction that started the access.

Optional Feature:
- Macro MEM_TIMEOUT_EN.
- Defined:
  - An 8-bit counter clears on entry to BUSY and increments each BUSY cycle.
  - When the count reaches MEM_TIMEOUT-1 without mem_ack, that cycle counts as completion. mem_rdata is replaced by 0 for wb_data, and mem_error is set.
  - mem_error stays set until reset.
  - A simultaneous mem_ack wins: real data is used and no error is flagged.
- Undefined:
  - No counter; BUSY waits for mem_ack indefinitely.
  - mem_error is tied to 0.

Test Plan:
- ALU op, ALU_out=0x0000_00A5, Mux_flag_2=1, rd=5, banco=1, no mem flags -> after 1 negedge: wb_data=0xA5, wb_reg=5, wb_we=1; MEM_stall=0 throughout.
- Load, ALU_out=0x100, rt=9, Mux_flag_2=0, Mux_flag_3=1, ack 3 cycles after req with mem_rdata=0xDEADBEEF:
  - mem_req=1, mem_addr=0x100, mem_we=0.
  - MEM_stall high until the ack cycle.
  - wb_data=0xDEADBEEF, wb_reg=9, wb_we=1 one edge after ack.
  - mem_req low one edge after ack.
- Store, ALU_out=0x20, dato_B=0x1234, banco=0, ack in first BUSY cycle -> mem_we=1, mem_wdata=0x1234, wb_we=0, total 2 cycles; a following ALU op retires on the next edge.
- Both rd and wr flags set -> treated as a store (mem_we=1); mem_error stays 0.
- rst_n low while BUSY -> mem_req, MEM_stall, wb_we, mem_error all 0 immediately; a later mem_ack is ignored.
- MEM_TIMEOUT_EN, MEM_TIMEOUT=4, load with no ack -> completes after 4 BUSY cycles; wb_data=0 (Mux_flag_3=1); mem_error=1 and sticky across subsequent ops.
